// File: rtl/irda_rx_crc32.sv
// rtl/irda_rx_crc32.sv - FIR receive CRC-32 checker with 32-bit FCS-stripping delay line
module irda_rx_crc32 #(
    parameter logic [31:0] RESIDUE = 32'hC704DD7B
) (
    input  logic        clk,
    input  logic        wb_rst_i,
    input  logic        fir_rx4_enable,
    input  logic        rxdin,
    input  logic        rx_sof,
    input  logic        rx_eof,
    output logic        rxdout,
    output logic        rxdout_valid,
    output logic        crc_ok,
    output logic        crc_err,
    output logic        frame_short,
    output logic [31:0] crc_reg
);

    // Generator taps excluding bit 0, which receives the feedback bit directly.
    localparam logic [31:0] POLY_TAPS = 32'h04C11DB6;

    logic [31:0] crc_q, crc_d;
    logic [31:0] dly_q, dly_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        rxdout_q, rxdout_d;
    logic        rxdout_valid_q, rxdout_valid_d;
    logic        crc_ok_q, crc_ok_d;
    logic        crc_err_q, crc_err_d;
    logic        frame_short_q, frame_short_d;
    logic        shin;

    // Frame state update: optional sof clear, bit absorb, then eof evaluate-and-clear.
    always_comb begin
        crc_d          = crc_q;
        dly_d          = dly_q;
        cnt_d          = cnt_q;
        rxdout_d       = rxdout_q;
        rxdout_valid_d = 1'b0;
        crc_ok_d       = 1'b0;
        crc_err_d      = 1'b0;
        frame_short_d  = 1'b0;
        shin           = 1'b0;

        // A lone sof clears first so a same-cycle bit starts the new frame.
        if (rx_sof && !rx_eof) begin
            crc_d = 32'hFFFFFFFF;
            dly_d = 32'd0;
            cnt_d = 6'd0;
        end

        if (fir_rx4_enable) begin
            shin  = crc_d[31] ^ rxdin;
            crc_d = {crc_d[30:0], shin} ^ ({32{shin}} & POLY_TAPS);
            if (cnt_d == 6'd32) begin
                rxdout_d       = dly_d[31];
                rxdout_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_d + 6'd1;
            end
            dly_d = {dly_d[30:0], rxdin};
        end

        // Evaluation sees the same-cycle bit; that bit never leaks into the next frame.
        if (rx_eof) begin
            if (cnt_d < 6'd32) begin
                crc_err_d     = 1'b1;
                frame_short_d = 1'b1;
            end else if (crc_d == RESIDUE) begin
                crc_ok_d = 1'b1;
            end else begin
                crc_err_d = 1'b1;
            end
            crc_d = 32'hFFFFFFFF;
            dly_d = 32'd0;
            cnt_d = 6'd0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            crc_q          <= 32'hFFFFFFFF;
            dly_q          <= 32'd0;
            cnt_q          <= 6'd0;
            rxdout_q       <= 1'b0;
            rxdout_valid_q <= 1'b0;
            crc_ok_q       <= 1'b0;
            crc_err_q      <= 1'b0;
            frame_short_q  <= 1'b0;
        end else begin
            crc_q          <= crc_d;
            dly_q          <= dly_d;
            cnt_q          <= cnt_d;
            rxdout_q       <= rxdout_d;
            rxdout_valid_q <= rxdout_valid_d;
            crc_ok_q       <= crc_ok_d;
            crc_err_q      <= crc_err_d;
            frame_short_q  <= frame_short_d;
        end
    end

    assign rxdout       = rxdout_q;
    assign rxdout_valid = rxdout_valid_q;
    assign crc_ok       = crc_ok_q;
    assign crc_err      = crc_err_q;
    assign frame_short  = frame_short_q;
    assign crc_reg      = crc_q;

endmodule

// File: tb/tb_irda_rx_crc32.sv
// tb/tb_irda_rx_crc32.sv - scoreboard bench for irda_rx_crc32
module tb_irda_rx_crc32;

    localparam logic [31:0] RESIDUE = 32'hC704DD7B;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        fir_rx4_enable;
    logic        rxdin;
    logic        rx_sof;
    logic        rx_eof;
    logic        rxdout;
    logic        rxdout_valid;
    logic        crc_ok;
    logic        crc_err;
    logic        frame_short;
    logic [31:0] crc_reg;

    irda_rx_crc32 #(.RESIDUE(RESIDUE)) dut (
        .clk            (clk),
        .wb_rst_i       (wb_rst_i),
        .fir_rx4_enable (fir_rx4_enable),
        .rxdin          (rxdin),
        .rx_sof         (rx_sof),
        .rx_eof         (rx_eof),
        .rxdout         (rxdout),
        .rxdout_valid   (rxdout_valid),
        .crc_ok         (crc_ok),
        .crc_err        (crc_err),
        .frame_short    (frame_short),
        .crc_reg        (crc_reg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int vcount   = 0;

    logic [31:0] m_crc;
    int          m_cnt;
    logic        pending[$];
    logic        exp_bits[$];
    logic [2:0]  exp_res[$];
    logic        fr[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        if (c[31] ^ b) return (c << 1) ^ 32'h04C11DB7;
        return c << 1;
    endfunction

    task automatic model_clear();
        m_crc = 32'hFFFFFFFF;
        m_cnt = 0;
        pending.delete();
    endtask

    task automatic drive(input logic en, input logic b, input logic sof, input logic eof);
        @(posedge clk);
        #1;
        fir_rx4_enable = en;
        rxdin          = b;
        rx_sof         = sof;
        rx_eof         = eof;
        if (sof && !eof) model_clear();
        if (en) begin
            m_crc = crc_step(m_crc, b);
            m_cnt++;
            pending.push_back(b);
            if (pending.size() > 32) exp_bits.push_back(pending.pop_front());
        end
        if (eof) begin
            if (m_cnt < 32)          exp_res.push_back(3'b011);
            else if (m_crc == RESIDUE) exp_res.push_back(3'b100);
            else                     exp_res.push_back(3'b010);
            model_clear();
        end
    endtask

    task automatic build_good(input int flip);
        logic [71:0] pl;
        logic [31:0] fcs;
        pl  = "123456789";
        fcs = 32'hFC891918;
        fr.delete();
        for (int i = 0; i < 72; i++) fr.push_back(pl[71-i] ^ (i == flip));
        for (int i = 0; i < 32; i++) fr.push_back(fcs[31-i]);
    endtask

    task automatic send_all_but_last();
        for (int i = 0; i < fr.size() - 1; i++) drive(1'b1, fr[i], 1'b0, 1'b0);
    endtask

    // Output monitor: pops the scoreboard queues whenever the DUT reports.
    always @(negedge clk) begin
        if (!wb_rst_i) begin
            if (rxdout_valid) begin
                vcount++;
                if (exp_bits.size() == 0) check("rxdout_extra", 32'd1, 32'd0);
                else check("rxdout", {31'd0, rxdout}, {31'd0, exp_bits.pop_front()});
            end
            if (crc_ok || crc_err || frame_short) begin
                if (exp_res.size() == 0) check("result_extra", {29'd0, crc_ok, crc_err, frame_short}, 32'd0);
                else check("result", {29'd0, crc_ok, crc_err, frame_short}, {29'd0, exp_res.pop_front()});
            end
        end
    end

    initial begin
        int v0;
        wb_rst_i       = 1'b1;
        fir_rx4_enable = 1'b0;
        rxdin          = 1'b0;
        rx_sof         = 1'b0;
        rx_eof         = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_crc", crc_reg, 32'hFFFFFFFF);
        check("reset_outs", {27'd0, rxdout, rxdout_valid, crc_ok, crc_err, frame_short}, 32'd0);
        wb_rst_i = 1'b0;

        // Good frame, eof in its own cycle.
        v0 = vcount;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        build_good(-1);
        foreach (fr[i]) drive(1'b1, fr[i], 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("good_residue", crc_reg, RESIDUE);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        check("good_vcount", vcount - v0, 32'd72);

        // Corrupted payload bit 10.
        v0 = vcount;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        build_good(10);
        foreach (fr[i]) drive(1'b1, fr[i], 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("bad_crc_differs", {31'd0, crc_reg == RESIDUE}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        check("bad_vcount", vcount - v0, 32'd72);

        // Short frame.
        v0 = vcount;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        check("short_vcount", vcount - v0, 32'd0);

        // Back-to-back good frames, final bit strobed with eof, no sof for the second.
        v0 = vcount;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        build_good(-1);
        send_all_but_last();
        drive(1'b1, fr[fr.size()-1], 1'b0, 1'b1);
        send_all_but_last();
        drive(1'b1, fr[fr.size()-1], 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("b2b_crc_cleared", crc_reg, 32'hFFFFFFFF);
        repeat (3) @(posedge clk);
        check("b2b_vcount", vcount - v0, 32'd144);

        // Strobe together with sof.
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("sof_bit_crc", crc_reg, crc_step(32'hFFFFFFFF, 1'b1));
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // sof and eof together: old frame gets the bit, new frame starts empty.
        v0 = vcount;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        build_good(-1);
        send_all_but_last();
        drive(1'b1, fr[fr.size()-1], 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("sofeof_crc_cleared", crc_reg, 32'hFFFFFFFF);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        check("sofeof_vcount", vcount - v0, 32'd72);

        // Reset mid-frame.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        wb_rst_i       = 1'b1;
        fir_rx4_enable = 1'b0;
        #1;
        check("midrst_crc", crc_reg, 32'hFFFFFFFF);
        check("midrst_outs", {27'd0, rxdout, rxdout_valid, crc_ok, crc_err, frame_short}, 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        wb_rst_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bits_drained", exp_bits.size(), 32'd0);
        check("results_drained", exp_res.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
